tt_um_xor_stream_decryptor: RTL and testbench
=============================================

# tt_um_xor_stream_decryptor

Receive-side counterpart to the team's XOR encryption tile. It decrypts one ciphertext byte per host strobe, using either a static 8-bit key (inverse of the static XOR encryptor) or a rolling keystream from an 8-bit Galois LFSR seeded with the key. The tile is a TinyTapeout user module. The host drives bytes and commands on the dedicated and bidirectional pins, and reads plaintext plus status flags back.

## Interface
- No parameters. Pin map and LFSR polynomial are fixed.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  ignored.
- ui_in  in  8  ciphertext byte or key byte, selected by command bits.
- uio_in  in  8  control bits, used in [3:0]:
  - [0] stb: host byte strobe, asynchronous to clk.
  - [1] key_ld: key load command.
  - [2] mode: 0 = static key, 1 = rolling LFSR.
  - [3] clr: rewind command.
  - [7:4] ignored.
- uo_out  out  8  last plaintext byte.
- uio_out  out  8  status bits:
  - [4] out_valid.
  - [5] key_ok.
  - [6] tog: flips on every new plaintext byte.
  - [7] err: sticky.
  - [3:0] = 0.
- uio_oe  out  8  constant 8'hF0.

## Operation
- Strobe synchronizer: stb passes through flops s1→s2, then s3 holds the previous s2.
  - Accept event = s2 & ~s3.
  - All other inputs (ui_in, key_ld, mode, clr) are sampled unsynchronized on the accept edge. The host holds them stable from stb rise until 4 cycles later.
- Commands on accept, in priority order:
  1. key_ld=1: key←ui_in, lfsr←ui_in, key_ok←(ui_in≠0), err←0, out_valid←0, uo_out←0. tog unchanged.
  2. key_ld=0, clr=1: lfsr←key, err←0, out_valid←0, uo_out←0. key and key_ok unchanged.
  3. Data with key_ok=0: err←1. uo_out, tog, out_valid and lfsr unchanged.
  4. Data with key_ok=1, mode=0: uo_out←ui_in^key, out_valid←1, tog←~tog. lfsr unchanged.
  5. Data with key_ok=1, mode=1: uo_out←ui_in^lfsr, out_valid←1, tog←~tog, lfsr←step(lfsr).
- LFSR step (Galois, taps 8'hB8): step(x) = (x>>1) ^ (x[0] ? 8'hB8 : 8'h00).
  - Key 0x00 is rejected through key_ok=0, so the all-zero lock-up state is never used.
- mode is sampled per byte, so static and rolling bytes may interleave. Static bytes do not advance the LFSR.
- The held value of stb is ignored; only a rising edge produces an event. A strobe held high produces exactly one event.

## Timing
- Reset (asynchronous) values:
  - uo_out=0x00, uio_out=0x00.
  - key=0, lfsr=0, key_ok=0, out_valid=0, tog=0, err=0.
  - s1=s2=s3=1. A strobe held high across reset release is never accepted; the host must drop stb and raise it again.
- Latency: stb sampled high at clock edge k makes s1=1. The accept event is active during the cycle after edge k+1. Register updates land at edge k+2, and outputs are visible after edge k+2.
- Minimum stb high time is 3 cycles, and minimum low time is 3 cycles. Shorter pulses may be dropped, never double-counted.
- Maximum throughput: one byte per 6 cycles.
- Reset asserted mid-operation clears everything immediately. The key must be reloaded afterwards.
- uio_oe is never sequential and is constant 8'hF0 in and out of reset.

## Test plan
- **Reset:** drive rst_n=0 with stb=1, then release while stb stays 1 for 10 cycles.
  - Required: uo_out=0x00, uio_out=0x00, uio_oe=0xF0, and no event; tog stays 0.
- **Static mode:** key_ld with ui_in=0xBE, then data mode=0 with ui_in=0xFF.
  - Required: key_ok=1, then uo_out=0x41, out_valid=1, tog=1, on edge k+2.
- **Rolling mode:** key_ld 0x01, then three data strobes mode=1 with ui_in=0x00.
  - Required: uo_out = 0x01, 0xB8, 0x5C, and tog toggles each time.
  - Then clr followed by a data strobe with 0x00: required uo_out=0x01 (rewound).
- **Error path:** after reset, data strobe with 0x55.
  - Required: err=1, uo_out=0x00, tog=0.
  - Then key_ld 0x00: required err=0, key_ok=0.
  - Then a data strobe: required err=1 again.
- **Edge handling:** hold stb high for 50 cycles.
  - Required: exactly one tog flip.
  - Then a 1-cycle stb pulse: required either 0 or 1 events, never 2.
- **Priority:** strobe with key_ld=1 and clr=1, ui_in=0x3C.
  - Required: key loaded as 0x3C; a following mode=0 data strobe with 0x3C gives uo_out=0x00.

Source files
------------

// File: rtl/tt_um_xor_stream_decryptor.sv
// XOR stream decryptor tile: one ciphertext byte per host strobe, decrypted with
// either a static key or a rolling Galois-LFSR keystream seeded from that key.
module tt_um_xor_stream_decryptor (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [7:0] TAPS = 8'hB8;

  logic       stb;
  logic       key_ld;
  logic       mode;
  logic       clr;
  logic       s1_reg;
  logic       s2_reg;
  logic       s3_reg;
  logic       accept;

  logic [7:0] key_reg;
  logic [7:0] key_next;
  logic [7:0] lfsr_reg;
  logic [7:0] lfsr_next;
  logic [7:0] lfsr_step;
  logic [7:0] pt_reg;
  logic [7:0] pt_next;
  logic       key_ok_reg;
  logic       key_ok_next;
  logic       out_valid_reg;
  logic       out_valid_next;
  logic       tog_reg;
  logic       tog_next;
  logic       err_reg;
  logic       err_next;

  logic       unused_ok;

  assign stb    = uio_in[0];
  assign key_ld = uio_in[1];
  assign mode   = uio_in[2];
  assign clr    = uio_in[3];

  assign unused_ok = &{1'b0, ena, uio_in[7:4]};

  // Synchronizer flops come out of reset high so a strobe already held high
  // at reset release never looks like a rising edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= 1'b1;
      s2_reg <= 1'b1;
      s3_reg <= 1'b1;
    end else begin
      s1_reg <= stb;
      s2_reg <= s1_reg;
      s3_reg <= s2_reg;
    end
  end

  assign accept = s2_reg & ~s3_reg;

  // Galois step: shift right, fold the tap mask in when bit 0 falls out.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_step
      if (gi == 7) begin : g_top
        assign lfsr_step[gi] = lfsr_reg[0] & TAPS[gi];
      end else begin : g_low
        assign lfsr_step[gi] = lfsr_reg[gi+1] ^ (lfsr_reg[0] & TAPS[gi]);
      end
    end
  endgenerate

  always_comb begin
    key_next       = key_reg;
    lfsr_next      = lfsr_reg;
    pt_next        = pt_reg;
    key_ok_next    = key_ok_reg;
    out_valid_next = out_valid_reg;
    tog_next       = tog_reg;
    err_next       = err_reg;
    if (accept) begin
      if (key_ld) begin
        key_next       = ui_in;
        lfsr_next      = ui_in;
        key_ok_next    = (ui_in != 8'h00);
        err_next       = 1'b0;
        out_valid_next = 1'b0;
        pt_next        = 8'h00;
      end else if (clr) begin
        lfsr_next      = key_reg;
        err_next       = 1'b0;
        out_valid_next = 1'b0;
        pt_next        = 8'h00;
      end else if (!key_ok_reg) begin
        err_next = 1'b1;
      end else if (!mode) begin
        pt_next        = ui_in ^ key_reg;
        out_valid_next = 1'b1;
        tog_next       = ~tog_reg;
      end else begin
        pt_next        = ui_in ^ lfsr_reg;
        lfsr_next      = lfsr_step;
        out_valid_next = 1'b1;
        tog_next       = ~tog_reg;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_reg       <= 8'h00;
      lfsr_reg      <= 8'h00;
      pt_reg        <= 8'h00;
      key_ok_reg    <= 1'b0;
      out_valid_reg <= 1'b0;
      tog_reg       <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      key_reg       <= key_next;
      lfsr_reg      <= lfsr_next;
      pt_reg        <= pt_next;
      key_ok_reg    <= key_ok_next;
      out_valid_reg <= out_valid_next;
      tog_reg       <= tog_next;
      err_reg       <= err_next;
    end
  end

  assign uo_out  = pt_reg;
  assign uio_out = {err_reg, tog_reg, key_ok_reg, out_valid_reg, 4'b0000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_xor_stream_decryptor.sv
// Bench for the XOR stream decryptor: a reference model pushes expected plaintext
// on every strobe; a monitor pops and compares whenever the tog flag flips.
module tb_tt_um_xor_stream_decryptor;

  logic       clk;
  logic       rst_n;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  logic       tog_prev;
  logic       lenient = 1'b0;
  int         flip_cnt = 0;

  logic [7:0] m_key, m_lfsr, m_uo;
  logic       m_key_ok, m_err, m_valid, m_tog;

  tt_um_xor_stream_decryptor dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] step(input logic [7:0] x);
    return (x >> 1) ^ (x[0] ? 8'hB8 : 8'h00);
  endfunction

  function automatic logic [7:0] model_status();
    return {m_err, m_tog, m_key_ok, m_valid, 4'h0};
  endfunction

  task automatic model_reset();
    m_key = 8'h00; m_lfsr = 8'h00; m_uo = 8'h00;
    m_key_ok = 1'b0; m_err = 1'b0; m_valid = 1'b0; m_tog = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_apply(input logic [7:0] d, input logic kl, input logic md,
                             input logic cl, input bit push);
    if (kl) begin
      m_key = d; m_lfsr = d; m_key_ok = (d != 8'h00);
      m_err = 1'b0; m_valid = 1'b0; m_uo = 8'h00;
    end else if (cl) begin
      m_lfsr = m_key; m_err = 1'b0; m_valid = 1'b0; m_uo = 8'h00;
    end else if (!m_key_ok) begin
      m_err = 1'b1;
    end else begin
      m_uo = d ^ (md ? m_lfsr : m_key);
      if (md) m_lfsr = step(m_lfsr);
      m_valid = 1'b1;
      m_tog = ~m_tog;
      if (push) exp_q.push_back(m_uo);
    end
  endtask

  // Scoreboard monitor: each tog flip is one produced plaintext byte.
  always @(negedge clk) begin
    if (!rst_n) begin
      tog_prev <= 1'b0;
    end else if (uio_out[6] !== tog_prev) begin
      tog_prev <= uio_out[6];
      flip_cnt++;
      if (exp_q.size() != 0) begin
        logic [7:0] e;
        e = exp_q.pop_front();
        checks++;
        if (uo_out !== e) begin
          errors++;
          $display("FAIL scoreboard_byte: uo_out=%02h expected=%02h", uo_out, e);
        end else begin
          $display("byte out: uo_out=%02h ok", uo_out);
        end
      end else if (!lenient) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: uo_out=%02h produced, expected none", uo_out);
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    uio_in = 8'h00;
    ui_in = 8'h00;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  // One host transaction: stb high 4 cycles with inputs held, then low 4 cycles.
  task automatic send(input logic [7:0] d, input logic kl, input logic md, input logic cl);
    @(negedge clk);
    ui_in = d;
    uio_in = {4'h0, cl, md, kl, 1'b1};
    model_apply(d, kl, md, cl, 1'b1);
    repeat (4) @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    $display("txn: ui_in=%02h key_ld=%0b mode=%0b clr=%0b -> uo_out=%02h uio_out=%02h",
             d, kl, md, cl, uo_out, uio_out);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    uio_in = 8'h01;
    ui_in = 8'hA5;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (uio_oe !== 8'hF0) begin
      errors++; $display("FAIL reset_oe_in_reset: uio_oe=%02h expected=f0", uio_oe);
    end
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    checks++;
    if (uo_out !== 8'h00) begin
      errors++; $display("FAIL reset_uo_out: uo_out=%02h expected=00", uo_out);
    end
    checks++;
    if (uio_out !== 8'h00) begin
      errors++; $display("FAIL reset_uio_out: uio_out=%02h expected=00", uio_out);
    end
    checks++;
    if (uio_oe !== 8'hF0) begin
      errors++; $display("FAIL reset_oe: uio_oe=%02h expected=f0", uio_oe);
    end
    uio_in = 8'h00;
    repeat (4) @(negedge clk);
    $display("reset: uo_out=%02h uio_out=%02h uio_oe=%02h", uo_out, uio_out, uio_oe);
  endtask

  task automatic test_static();
    send(8'hBE, 1'b1, 1'b0, 1'b0);
    checks++;
    if (uio_out !== 8'h20) begin
      errors++; $display("FAIL static_key_ok: uio_out=%02h expected=20", uio_out);
    end
    // Cycle-accurate latency: edge k samples stb, outputs change after edge k+2.
    @(negedge clk);
    ui_in = 8'hFF;
    uio_in = 8'h01;
    model_apply(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1);
    @(posedge clk);
    @(posedge clk); #1;
    checks++;
    if (uo_out !== 8'h00 || uio_out[6] !== 1'b0) begin
      errors++; $display("FAIL static_early: uo_out=%02h tog=%0b expected 00/0 after edge k+1",
                         uo_out, uio_out[6]);
    end
    @(posedge clk); #1;
    checks++;
    if (uo_out !== 8'h41) begin
      errors++; $display("FAIL static_data: uo_out=%02h expected=41", uo_out);
    end
    checks++;
    if (uio_out !== 8'h70) begin
      errors++; $display("FAIL static_status: uio_out=%02h expected=70", uio_out);
    end
    repeat (3) @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (4) @(negedge clk);
    $display("static: uo_out=%02h uio_out=%02h", uo_out, uio_out);
  endtask

  task automatic test_rolling();
    logic [7:0] exp_roll[3];
    logic       tog_before;
    exp_roll = '{8'h01, 8'hB8, 8'h5C};
    send(8'h01, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tog_before = uio_out[6];
      send(8'h00, 1'b0, 1'b1, 1'b0);
      checks++;
      if (uo_out !== exp_roll[i]) begin
        errors++; $display("FAIL rolling_byte%0d: uo_out=%02h expected=%02h", i, uo_out, exp_roll[i]);
      end
      checks++;
      if (uio_out[6] !== ~tog_before) begin
        errors++; $display("FAIL rolling_tog%0d: tog=%0b expected=%0b", i, uio_out[6], ~tog_before);
      end
    end
    send(8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (uo_out !== 8'h00 || uio_out !== model_status()) begin
      errors++; $display("FAIL rolling_clr: uo_out=%02h uio_out=%02h expected 00/%02h",
                         uo_out, uio_out, model_status());
    end
    send(8'h00, 1'b0, 1'b1, 1'b0);
    checks++;
    if (uo_out !== 8'h01) begin
      errors++; $display("FAIL rolling_rewound: uo_out=%02h expected=01", uo_out);
    end
  endtask

  task automatic test_error();
    do_reset();
    send(8'h55, 1'b0, 1'b0, 1'b0);
    checks++;
    if (uio_out !== 8'h80 || uo_out !== 8'h00) begin
      errors++; $display("FAIL error_set: uio_out=%02h uo_out=%02h expected 80/00", uio_out, uo_out);
    end
    send(8'h00, 1'b1, 1'b0, 1'b0);
    checks++;
    if (uio_out !== 8'h00) begin
      errors++; $display("FAIL error_zero_key: uio_out=%02h expected=00", uio_out);
    end
    send(8'h12, 1'b0, 1'b1, 1'b0);
    checks++;
    if (uio_out !== 8'h80) begin
      errors++; $display("FAIL error_again: uio_out=%02h expected=80", uio_out);
    end
  endtask

  task automatic test_edge();
    int f0;
    int delta;
    send(8'h5A, 1'b1, 1'b0, 1'b0);
    f0 = flip_cnt;
    @(negedge clk);
    ui_in = 8'h11;
    uio_in = 8'h01;
    model_apply(8'h11, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (50) @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (flip_cnt - f0 != 1) begin
      errors++; $display("FAIL edge_held: tog flips=%0d expected=1", flip_cnt - f0);
    end
    $display("edge held: flips=%0d uo_out=%02h", flip_cnt - f0, uo_out);
    lenient = 1'b1;
    f0 = flip_cnt;
    @(negedge clk);
    ui_in = 8'h77;
    uio_in = 8'h01;
    @(negedge clk);
    uio_in[0] = 1'b0;
    repeat (8) @(negedge clk);
    lenient = 1'b0;
    delta = flip_cnt - f0;
    checks++;
    if (delta > 1) begin
      errors++; $display("FAIL edge_short_pulse: tog flips=%0d expected 0 or 1", delta);
    end
    if (delta == 1) model_apply(8'h77, 1'b0, 1'b0, 1'b0, 1'b0);
    checks++;
    if (uo_out !== m_uo || uio_out !== model_status()) begin
      errors++; $display("FAIL edge_short_state: uo_out=%02h uio_out=%02h expected %02h/%02h",
                         uo_out, uio_out, m_uo, model_status());
    end
    $display("edge short pulse: flips=%0d uo_out=%02h", delta, uo_out);
  endtask

  task automatic test_priority();
    send(8'h3C, 1'b1, 1'b0, 1'b1);
    checks++;
    if (uio_out[5] !== 1'b1 || uio_out[4] !== 1'b0 || uo_out !== 8'h00) begin
      errors++; $display("FAIL priority_load: uio_out=%02h uo_out=%02h expected key_ok=1 valid=0 uo=00",
                         uio_out, uo_out);
    end
    send(8'h3C, 1'b0, 1'b0, 1'b0);
    checks++;
    if (uo_out !== 8'h00 || uio_out[4] !== 1'b1) begin
      errors++; $display("FAIL priority_data: uo_out=%02h valid=%0b expected 00/1", uo_out, uio_out[4]);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic       md;
    send(8'hC3, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      d  = 8'($urandom_range(0, 255));
      md = 1'($urandom_range(0, 1));
      @(negedge clk);
      ui_in = d;
      uio_in = {5'h0, md, 2'b01};
      model_apply(d, 1'b0, md, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      uio_in[0] = 1'b0;
      @(negedge clk);
      $display("b2b txn: ui_in=%02h mode=%0b expected=%02h", d, md, m_uo);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (uio_out !== model_status() || uo_out !== m_uo) begin
      errors++; $display("FAIL b2b_final: uio_out=%02h uo_out=%02h expected %02h/%02h",
                         uio_out, uo_out, model_status(), m_uo);
    end
  endtask

  initial begin
    rst_n  = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    model_reset();
    test_reset();
    test_static();
    test_rolling();
    test_error();
    test_edge();
    test_priority();
    test_back_to_back();
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: %0d bytes never produced", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
